inverse_diffusion_layer: RTL

INVERSE_DIFFUSION_LAYER -- requirements
Module: inverse_diffusion_layer

---
 rtl/inverse_diffusion_layer.sv | 103 ++++++++++
 1 files changed

// File: rtl/inverse_diffusion_layer.sv
// Ascon inverse linear layer: L^-1 = L^63, evaluated as six commuting
// square-power steps over a 320-bit working register, one step per clock.
package ascon_pkg;
   typedef logic [4:0][63:0] t_state_array;
endpackage

module inverse_diffusion_layer
   import ascon_pkg::*;
(
   input  logic         i_sys_clk,
   input  logic         i_sys_rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  t_state_array i_state,
   output logic         o_valid,
   input  logic         i_ready,
   output t_state_array o_state
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]   state;
   logic [2:0]   cnt;
   t_state_array work;

   function automatic logic [5:0] rot_a(input logic [2:0] r);
      case (r)
         3'd0:    return 6'd19;
         3'd1:    return 6'd61;
         3'd2:    return 6'd1;
         3'd3:    return 6'd10;
         default: return 6'd7;
      endcase
   endfunction

   function automatic logic [5:0] rot_b(input logic [2:0] r);
      case (r)
         3'd0:    return 6'd28;
         3'd1:    return 6'd39;
         3'd2:    return 6'd6;
         3'd3:    return 6'd17;
         default: return 6'd41;
      endcase
   endfunction

   // A zero amount falls out naturally as the identity rotation.
   function automatic logic [63:0] ror(input logic [63:0] x, input logic [5:0] n);
      logic [127:0] d;
      d = {x, x} >> n;
      return d[63:0];
   endfunction

   // Step k applies L^(2^k): rotation amounts scale by 2^k and wrap mod 64.
   function automatic t_state_array step(input t_state_array x, input logic [2:0] k);
      t_state_array y;
      logic [5:0]   sa;
      logic [5:0]   sb;
      for (int r = 0; r < 5; r++) begin
         sa   = rot_a(3'(r)) << k;
         sb   = rot_b(3'(r)) << k;
         y[r] = x[r] ^ ror(x[r], sa) ^ ror(x[r], sb);
      end
      return y;
   endfunction

   always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) begin
         state <= IDLE;
         cnt   <= 3'd0;
         work  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (i_valid) begin
                  work  <= i_state;
                  cnt   <= 3'd0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (cnt > 3'd5) begin
                  state <= DONE;
               end else begin
                  work <= step(work, cnt);
                  cnt  <= cnt + 3'd1;
                  if (cnt == 3'd5) state <= DONE;
               end
            end
            DONE: begin
               if (i_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_ready = (state == IDLE);
   assign o_valid = (state == DONE);
   assign o_state = work;

endmodule
